// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        HALT   = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fq_entry_t;

    // Number of byte-offset bits inside one refill line.
    function automatic int line_off(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: QDEPTH x fq_entry_t, show-ahead head, single-cycle flush.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic      sys_clk,
    input  logic      rst_n,
    input  logic      i_flush,
    input  logic      i_push,
    input  logic      i_pop,
    input  fq_entry_t i_data,
    output fq_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    fq_entry_t     r_mem [QDEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(QDEPTH));
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Entry storage; contents are only read through a valid count.
    always_ff @(posedge sys_clk) begin
        // NOTE: storage array is deliberately not reset; r_count alone decides what is valid.
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ifetch_pq.sv
// Instruction-fetch front end: sequential fetch from a one-line buffer,
// line refill on miss, redirect flush and halt at a fixed address.
module ifetch_pq
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] HALT_PC   = 32'h0000_8000,
    parameter int          LINE_BITS = 256,
    parameter int          QDEPTH    = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    input  logic                 deq_ready,
    output logic                 deq_valid,
    output logic [31:0]          ins_out,
    output logic [31:0]          pc_out,
    output logic [31:0]          next_pc_out,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_done,
    input  logic [LINE_BITS-1:0] mem_data,
    output logic                 halted
);
    localparam int OFF = line_off(LINE_BITS);

    fetch_state_t         r_state;
    logic [31:0]          r_fetch_pc;
    logic [31:0]          r_mem_addr;
    logic                 r_lb_valid;
    logic [31:OFF]        r_lb_tag;
    logic [LINE_BITS-1:0] r_lb_data;

    fetch_state_t w_next_state;
    logic [31:0]  w_next_pc;
    logic [31:0]  w_redirect_target;
    logic [31:0]  w_lb_word;
    logic         w_hit;
    logic         w_push;
    logic         w_pop;
    logic         w_start_refill;
    logic         w_fill;
    logic         w_full;
    logic         w_empty;
    fq_entry_t    w_head;

    assign w_redirect_target = redirect_pc & ~32'h3;
    assign w_hit     = r_lb_valid && (r_lb_tag == r_fetch_pc[31:OFF]);
    assign w_lb_word = r_lb_data[{r_fetch_pc[OFF-1:2], 5'b0_0000} +: 32];
    assign w_pop     = deq_valid && deq_ready && !redirect;

    // Next-state, fetch-address and queue-push decisions; redirect overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state   = r_state;
        w_next_pc      = r_fetch_pc;
        w_push         = 1'b0;
        w_start_refill = 1'b0;
        w_fill         = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_fetch_pc == HALT_PC) begin
                    w_next_state = HALT;
                end else if (w_hit) begin
                    if (!w_full) begin
                        w_push    = 1'b1;
                        w_next_pc = r_fetch_pc + 32'd4;
                    end
                end else begin
                    w_next_state   = REFILL;
                    w_start_refill = 1'b1;
                end
            end
            REFILL: begin
                if (mem_done) begin
                    w_fill       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = IDLE;
        endcase
        // An outstanding refill is always completed, so REFILL survives a redirect.
        if (redirect) begin
            w_push         = 1'b0;
            w_start_refill = 1'b0;
            w_next_pc      = w_redirect_target;
            if (r_state != REFILL || mem_done) w_next_state = IDLE;
        end
    end

    // FSM, fetch PC, refill address and line-buffer tag registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= '0;
            r_lb_valid <= 1'b0;
            r_lb_tag   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_pc;
            if (w_start_refill) r_mem_addr <= {r_fetch_pc[31:OFF], {OFF{1'b0}}};
            if (w_fill) begin
                r_lb_valid <= 1'b1;
                r_lb_tag   <= r_mem_addr[31:OFF];
            end
        end
    end

    // Line-buffer data; qualified by r_lb_valid, so it needs no reset.
    always_ff @(posedge sys_clk) begin
        if (w_fill) r_lb_data <= mem_data;
    end

    ifetch_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ('{pc: r_fetch_pc, ins: w_lb_word}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign deq_valid   = !w_empty;
    assign ins_out     = w_empty ? 32'd0 : w_head.ins;
    assign pc_out      = w_empty ? 32'd0 : w_head.pc;
    assign next_pc_out = w_empty ? 32'd0 : w_head.pc + 32'd4;
    assign mem_req     = (r_state == REFILL);
    assign mem_addr    = r_mem_addr;
    assign halted      = (r_state == HALT) && w_empty;

endmodule

// File: tb/tb_ifetch_pq.sv
// Self-checking bench for ifetch_pq: directed scenarios followed by a random
// phase, all compared every cycle against a queue-based reference model.
module tb_ifetch_pq;

    localparam logic [31:0] RESET_PC  = 32'h0000_1000;
    localparam logic [31:0] HALT_PC   = 32'h0000_8000;
    localparam int          LINE_BITS = 256;
    localparam int          QDEPTH    = 4;
    localparam int          LINE_B    = LINE_BITS / 8;

    logic                 sys_clk;
    logic                 rst_n;
    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic                 deq_ready;
    logic                 deq_valid;
    logic [31:0]          ins_out;
    logic [31:0]          pc_out;
    logic [31:0]          next_pc_out;
    logic                 mem_req;
    logic [31:0]          mem_addr;
    logic                 mem_done;
    logic [LINE_BITS-1:0] mem_data;
    logic                 halted;

    ifetch_pq #(
        .RESET_PC (RESET_PC),
        .HALT_PC  (HALT_PC),
        .LINE_BITS(LINE_BITS),
        .QDEPTH   (QDEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .deq_ready  (deq_ready),
        .deq_valid  (deq_valid),
        .ins_out    (ins_out),
        .pc_out     (pc_out),
        .next_pc_out(next_pc_out),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_done   (mem_done),
        .mem_data   (mem_data),
        .halted     (halted)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } tb_ent_t;

    tb_ent_t     m_q[$];
    logic [31:0] m_pc;
    bit          m_line_ok;
    logic [31:0] m_line_base;
    bit          m_refill;
    logic [31:0] m_raddr;
    bit          m_halt;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  wait_cnt;
    int  mem_lat = 3;
    bit  rand_lat = 0;
    bit  stale_done = 0;
    logic [31:0] seen[$];

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~(LINE_B - 1);
    endfunction

    function automatic logic [LINE_BITS-1:0] line_image(input logic [31:0] base);
        logic [LINE_BITS-1:0] img;
        for (int k = 0; k < LINE_BITS / 32; k++) img[32*k +: 32] = ins_of(base + 32'(4 * k));
        return img;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc      = RESET_PC;
        m_line_ok = 0;
        m_line_base = '0;
        m_refill  = 0;
        m_raddr   = '0;
        m_halt    = 0;
        wait_cnt  = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        int          sz = m_q.size();
        bit          do_deq = (sz != 0) && deq_ready && !redirect;
        bit          do_enq = 0;
        bit          fill = m_refill && mem_done;
        logic [31:0] old_pc = m_pc;
        if (redirect) begin
            m_pc   = redirect_pc & ~32'h3;
            m_halt = 0;
        end else if (!m_refill && !m_halt) begin
            if (m_pc == HALT_PC) m_halt = 1;
            else if (m_line_ok && line_of(m_pc) == m_line_base) begin
                if (sz < QDEPTH) begin
                    do_enq = 1;
                    m_pc   = m_pc + 4;
                end
            end else begin
                m_refill = 1;
                m_raddr  = line_of(m_pc);
                wait_cnt = 0;
                if (rand_lat) mem_lat = $urandom_range(0, 5);
            end
        end
        if (fill) begin
            m_line_ok   = 1;
            m_line_base = m_raddr;
            m_refill    = 0;
        end
        if (redirect) m_q.delete();
        else begin
            if (do_deq) void'(m_q.pop_front());
            if (do_enq) m_q.push_back('{pc: old_pc, ins: ins_of(old_pc)});
        end
    endtask

    task automatic check_outputs();
        bit ne = (m_q.size() != 0);
        check("deq_valid", {31'd0, deq_valid}, {31'd0, ne});
        check("pc_out", pc_out, ne ? m_q[0].pc : 32'd0);
        check("ins_out", ins_out, ne ? m_q[0].ins : 32'd0);
        check("next_pc_out", next_pc_out, ne ? m_q[0].pc + 32'd4 : 32'd0);
        check("mem_req", {31'd0, mem_req}, {31'd0, m_refill});
        if (m_refill) check("mem_addr", mem_addr, m_raddr);
        check("halted", {31'd0, halted}, {31'd0, (m_halt && !ne)});
    endtask

    // One clock: drive memory response, step the model, then compare after the edge.
    task automatic cycle(input logic rdr, input logic [31:0] rpc);
        redirect    = rdr;
        redirect_pc = rpc;
        mem_done    = 1'b0;
        mem_data    = '0;
        if (m_refill) begin
            if (wait_cnt >= mem_lat) begin
                mem_done = 1'b1;
                mem_data = line_image(m_raddr);
                wait_cnt = 0;
            end else wait_cnt++;
        end else if (stale_done) begin
            mem_done = 1'b1;
            mem_data = {(LINE_BITS / 32){32'hDEAD_BEEF}};
        end
        stale_done = 0;
        model_step();
        @(posedge sys_clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
        mem_done = 1'b0; mem_data = '0;
        model_reset();
        #1;
        check("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        check("rst_ins_out", ins_out, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_next_pc", next_pc_out, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;

        // 1: first refill, streaming line, next-line refill
        deq_ready = 1'b1;
        cycle(0, 0);
        check("t1_mem_req", {31'd0, mem_req}, 32'd1);
        check("t1_mem_addr", mem_addr, 32'h1000);
        for (int i = 0; i < 20 && !deq_valid; i++) cycle(0, 0);
        for (int k = 0; k < 8; k++) begin
            check("t1_stream_pc", pc_out, 32'h1000 + 32'(4 * k));
            cycle(0, 0);
        end
        for (int i = 0; i < 5 && !mem_req; i++) cycle(0, 0);
        check("t1_next_req", {31'd0, mem_req}, 32'd1);
        check("t1_next_addr", mem_addr, 32'h1020);

        // 2: back to line 0x1000 with decode stalled, then drain
        deq_ready = 1'b0;
        cycle(1, 32'h1000);
        repeat (40) cycle(0, 0);
        check("t2_full_valid", {31'd0, deq_valid}, 32'd1);
        check("t2_head_hold", pc_out, 32'h1000);
        deq_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t2_drain_pc", pc_out, 32'h1000 + 32'(4 * k));
            cycle(0, 0);
        end

        // 3: redirect into the cached line while three entries are queued
        deq_ready = 1'b0;
        cycle(1, 32'h1000);
        for (int i = 0; i < 40 && m_q.size() < 3; i++) cycle(0, 0);
        cycle(1, 32'h1013);
        check("t3_flushed", {31'd0, deq_valid}, 32'd0);
        cycle(0, 0);
        check("t3_head_pc", pc_out, 32'h1010);
        check("t3_no_refill", {31'd0, mem_req}, 32'd0);

        // 4: redirect during the refill of 0x1020
        deq_ready = 1'b1;
        mem_lat   = 6;
        for (int i = 0; i < 40 && !mem_req; i++) cycle(0, 0);
        check("t4_req", {31'd0, mem_req}, 32'd1);
        check("t4_addr", mem_addr, 32'h1020);
        cycle(1, 32'h2000);
        for (int i = 0; i < 40 && mem_req; i++) begin
            check("t4_addr_stable", mem_addr, 32'h1020);
            cycle(0, 0);
        end
        for (int i = 0; i < 20 && !mem_req; i++) cycle(0, 0);
        check("t4_new_req", {31'd0, mem_req}, 32'd1);
        check("t4_new_addr", mem_addr, 32'h2000);

        // 5: run up to the halt address
        mem_lat = 3;
        cycle(1, 32'h7FF8);
        seen.delete();
        for (int i = 0; i < 60; i++) begin
            if (deq_valid) seen.push_back(pc_out);
            cycle(0, 0);
        end
        check("t5_count", 32'(seen.size()), 32'd2);
        if (seen.size() >= 2) begin
            check("t5_pc0", seen[0], 32'h7FF8);
            check("t5_pc1", seen[1], 32'h7FFC);
        end
        check("t5_halted", {31'd0, halted}, 32'd1);
        cycle(1, 32'h1000);
        check("t5_unhalt", {31'd0, halted}, 32'd0);

        // 6: reset in the middle of a refill, stale mem_done afterwards
        mem_lat = 20;
        for (int i = 0; i < 10 && !mem_req; i++) cycle(0, 0);
        cycle(0, 0);
        check("t6_req_before", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_req_dropped", {31'd0, mem_req}, 32'd0);
        check("t6_valid_dropped", {31'd0, deq_valid}, 32'd0);
        model_reset();
        @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n      = 1'b1;
        mem_lat    = 3;
        stale_done = 1;
        cycle(0, 0);
        check("t6_restart_req", {31'd0, mem_req}, 32'd1);
        check("t6_restart_addr", mem_addr, 32'h1000);
        for (int i = 0; i < 20 && !deq_valid; i++) cycle(0, 0);
        check("t6_first_pc", pc_out, 32'h1000);
        check("t6_first_ins", ins_out, ins_of(32'h1000));

        // random phase
        rand_lat = 1;
        for (int i = 0; i < 2000; i++) begin
            int r = $urandom_range(0, 39);
            deq_ready = ($urandom_range(0, 9) < 7);
            if (!m_refill && $urandom_range(0, 19) == 0) stale_done = 1;
            if (r == 0)      cycle(1, 32'h1000 + 32'($urandom_range(0, 1023)));
            else if (r == 1) cycle(1, 32'h7F00 + 32'($urandom_range(0, 255)));
            else             cycle(0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
